// File: rtl/csa_pkg.sv
// Shared types for the pipelined carry-select adder.
// Optional feature macro: CSA_OVF_EN adds the sign bits needed for overflow.
package csa_pkg;

    localparam int CSA_WIDTH = 32;
    localparam int CSA_BLOCK = 8;
    localparam int NB        = CSA_WIDTH / CSA_BLOCK;

    // Candidate sum/carry of one block for carry-in 0 and carry-in 1
    typedef struct packed {
        logic [CSA_BLOCK-1:0] s0;
        logic                 c0;
        logic [CSA_BLOCK-1:0] s1;
        logic                 c1;
    } csa_pair_t;

    // Stage-1 register contents: block 0 is already resolved, blocks 1..NB-1 hold both candidates
    typedef struct packed {
        csa_pair_t [NB-1:1]   pairs;
        logic [CSA_BLOCK-1:0] b0_sum;
        logic                 b0_c;
`ifdef CSA_OVF_EN
        logic                 a_msb;
        logic                 b_msb;
`endif
    } csa_s1_t;

endpackage

// File: rtl/csa_block_gen.sv
// One carry-select slice: computes the block sum for both possible carry-ins.
module csa_block_gen
    import csa_pkg::*;
(
    input  logic [CSA_BLOCK-1:0] a_i,
    input  logic [CSA_BLOCK-1:0] b_i,
    output csa_pair_t            pair_o
);

    logic [CSA_BLOCK:0] t0;
    logic [CSA_BLOCK:0] t1;

    // Two BLOCK+1-bit adds; the top bit is the block carry-out
    always_comb begin
        t0 = {1'b0, a_i} + {1'b0, b_i};
        t1 = {1'b0, a_i} + {1'b0, b_i} + {{CSA_BLOCK{1'b0}}, 1'b1};
        pair_o.s0 = t0[CSA_BLOCK-1:0];
        pair_o.c0 = t0[CSA_BLOCK];
        pair_o.s1 = t1[CSA_BLOCK-1:0];
        pair_o.c1 = t1[CSA_BLOCK];
    end

endmodule

// File: rtl/csa_pipe_gen.sv
// Two-stage pipelined carry-select adder with valid/ready on both sides.
// Stage 1 registers per-block candidate pairs; stage 2 runs the select chain.
// WIDTH/BLOCK must match CSA_WIDTH/CSA_BLOCK in csa_pkg (the struct types are sized there).
// Optional feature macro: CSA_OVF_EN adds the registered signed-overflow output ovf.
module csa_pipe_gen
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int BLOCK = CSA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_OVF_EN
   ,output logic             ovf
`endif
);

    logic               s1_valid_q, s1_valid_d;
    logic               out_valid_q, out_valid_d;
    csa_s1_t            s1_q, s1_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               stage2_adv, in_accept;
    csa_pair_t [NB-1:1] pair_w;
    logic [BLOCK:0]     b0_w;

    // No skid buffer: stage 1 frees up only when it can move into stage 2
    assign stage2_adv = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready   = ~s1_valid_q | stage2_adv;
    assign in_accept  = in_valid & in_ready;

    genvar k;
    generate
        for (k = 1; k < NB; k++) begin : g_blk
            csa_block_gen u_blk (
                .a_i    (a[k*BLOCK +: BLOCK]),
                .b_i    (b[k*BLOCK +: BLOCK]),
                .pair_o (pair_w[k])
            );
        end
    endgenerate

    assign b0_w = {1'b0, a[BLOCK-1:0]} + {1'b0, b[BLOCK-1:0]} + {{BLOCK{1'b0}}, cin};

    // Stage-1 next state: block 0 resolved with the real cin, the rest as candidate pairs
    always_comb begin
        s1_d        = s1_q;
        s1_d.pairs  = pair_w;
        s1_d.b0_sum = b0_w[BLOCK-1:0];
        s1_d.b0_c   = b0_w[BLOCK];
`ifdef CSA_OVF_EN
        s1_d.a_msb  = a[WIDTH-1];
        s1_d.b_msb  = b[WIDTH-1];
`endif
    end

    // Stage-2 select chain: each block's resolved carry picks the next block's candidate
    always_comb begin
        logic sel;
        sel              = s1_q.b0_c;
        sum_d            = '0;
        sum_d[BLOCK-1:0] = s1_q.b0_sum;
        for (int i = 1; i < NB; i++) begin
            sum_d[i*BLOCK +: BLOCK] = sel ? s1_q.pairs[i].s1 : s1_q.pairs[i].s0;
            sel                     = sel ? s1_q.pairs[i].c1 : s1_q.pairs[i].c0;
        end
        cout_d = sel;
    end

    // Valid bits: stage 1 loads on accept or drains into stage 2; output holds until taken
    always_comb begin
        s1_valid_d  = in_accept ? 1'b1 : (stage2_adv ? 1'b0 : s1_valid_q);
        out_valid_d = stage2_adv ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    end

    // Pipeline state; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (in_accept)  s1_q <= s1_d;
            if (stage2_adv) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

`ifdef CSA_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: operands share a sign and the result sign differs
    always_comb ovf_d = (s1_q.a_msb == s1_q.b_msb) & (sum_d[WIDTH-1] != s1_q.a_msb);

    // Overflow flag registered alongside sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ovf_q <= 1'b0;
        else if (stage2_adv) ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_csa_pipe_gen.sv
// Directed table plus handshake/reset sequences for csa_pipe_gen.
module tb_csa_pipe_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        cin;
    logic        out_valid, out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef CSA_OVF_EN
    logic        ovf;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    csa_pipe_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSA_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[12];

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
    } exp_t;

    exp_t q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, got, stall, stale;
        exp_t e;
        logic [32:0] full;
        logic        ev;

        //             a             b             cin   sum           cout  ovf
        vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2]  = '{32'h00FF00FF, 32'h0F0F0F0F, 1'b1, 32'h100E100F, 1'b0, 1'b0};
        vecs[3]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[7]  = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
        vecs[8]  = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[9]  = '{32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0};
        vecs[10] = '{32'hFFFFFF00, 32'h000000FF, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[11] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum",       {32'd0, sum},       64'd0);
        chk("rst_cout",      {63'd0, cout},      64'd0);
`ifdef CSA_OVF_EN
        chk("rst_ovf",       {63'd0, ovf},       64'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed table, one op at a time, latency checked
        for (int i = 0; i < 12; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; in_valid = 1'b1;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd2);
            chk($sformatf("tbl%0d_sum", i),  {32'd0, sum},  {32'd0, vecs[i].s});
            chk($sformatf("tbl%0d_cout", i), {63'd0, cout}, {63'd0, vecs[i].c});
`ifdef CSA_OVF_EN
            chk($sformatf("tbl%0d_ovf", i),  {63'd0, ovf},  {63'd0, vecs[i].v});
`endif
            tick();
            chk($sformatf("tbl%0d_retire", i), {63'd0, out_valid}, 64'd0);
        end

        // Backpressure: two fill the pipe, the third waits until the first retires
        out_ready = 1'b0;
        a = 32'd1; b = 32'd2; cin = 1'b0; in_valid = 1'b1;
        #1; chk("bp_rdyA", {63'd0, in_ready}, 64'd1);
        tick();
        a = 32'd10; b = 32'd20;
        #1; chk("bp_rdyB", {63'd0, in_ready}, 64'd1);
        tick();
        a = 32'd100; b = 32'd200;
        #1;
        chk("bp_full_rdy",  {63'd0, in_ready},  64'd0);
        chk("bp_full_vld",  {63'd0, out_valid}, 64'd1);
        chk("bp_full_sumA", {32'd0, sum},       64'd3);
        tick();
        chk("bp_hold_rdy",  {63'd0, in_ready},  64'd0);
        chk("bp_hold_sumA", {32'd0, sum},       64'd3);
        out_ready = 1'b1;
        #1; chk("bp_release_rdy", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_vldB", {63'd0, out_valid}, 64'd1);
        chk("bp_sumB", {32'd0, sum},       64'd30);
        tick();
        chk("bp_vldC", {63'd0, out_valid}, 64'd1);
        chk("bp_sumC", {32'd0, sum},       64'd300);
        tick();
        chk("bp_drain", {63'd0, out_valid}, 64'd0);

        // Streaming random ops against an in-order scoreboard
        out_ready = 1'b1; got = 0; stall = 0;
        for (int i = 0; i < 104; i++) begin
            if (i < 100) begin
                a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                ev   = (a[31] == b[31]) && (full[31] != a[31]);
                q.push_back('{full[31:0], full[32], ev});
            end else if (in_valid) begin
                stall++;
            end
            tick();
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("stream_spurious", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("stream%0d_sum", got), {31'd0, cout, sum}, {31'd0, e.c, e.s});
`ifdef CSA_OVF_EN
                    chk($sformatf("stream%0d_ovf", got), {63'd0, ovf}, {63'd0, e.v});
`endif
                    got++;
                end
            end
        end
        chk("stream_count", 64'(got),   64'd100);
        chk("stream_stall", 64'(stall), 64'd0);

        // Reset with two results in flight
        out_ready = 1'b0;
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 32'h33333333; b = 32'h44444444;
        tick();
        in_valid = 1'b0;
        chk("mid_full", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_sum", {32'd0, sum},       64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) stale++;
        end
        chk("mid_no_stale", 64'(stale), 64'd0);
        chk("mid_in_ready", {63'd0, in_ready}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
